// File: rtl/register_file_scoreboard_pkg.sv
// Shared defaults and helpers for the register file with busy scoreboard.
// Optional same-cycle write bypass: REGFILE_WRITE_BYPASS_EN.
package regfile_pkg;

  localparam int W_DEF      = 32;
  localparam int N_REGS_DEF = 16;

  typedef logic [N_REGS_DEF-1:0] busy_vec_t;

  function automatic int pc_index(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/register_file_scoreboard_if.sv
// Decode/writeback side bundle of the register file.
// master drives addresses and strobes, slave is the register file.
interface register_file_scoreboard_if #(
  parameter int W      = 32,
  parameter int N_REGS = 16
);
  localparam int AW = $clog2(N_REGS);

  logic [AW-1:0] inp_read_address0;
  logic [AW-1:0] inp_read_address1;
  logic [W-1:0]  out_read_data0;
  logic [W-1:0]  out_read_data1;
  logic          out_read_ready0;
  logic          out_read_ready1;
  logic          write_enable;
  logic [AW-1:0] inp_write_address0;
  logic [W-1:0]  inp_write_data;
  logic          inp_reserve_enable;
  logic [AW-1:0] inp_reserve_address;
  logic          out_reserve_stall;
  logic          inp_pc_enable;
  logic [W-1:0]  inp_write_data_pc;
  logic [W-1:0]  out_pc;

  modport master (
    output inp_read_address0, inp_read_address1,
    output write_enable, inp_write_address0, inp_write_data,
    output inp_reserve_enable, inp_reserve_address,
    output inp_pc_enable, inp_write_data_pc,
    input  out_read_data0, out_read_data1,
    input  out_read_ready0, out_read_ready1,
    input  out_reserve_stall, out_pc
  );

  modport slave (
    input  inp_read_address0, inp_read_address1,
    input  write_enable, inp_write_address0, inp_write_data,
    input  inp_reserve_enable, inp_reserve_address,
    input  inp_pc_enable, inp_write_data_pc,
    output out_read_data0, out_read_data1,
    output out_read_ready0, out_read_ready1,
    output out_reserve_stall, out_pc
  );

endinterface

// File: rtl/register_file_scoreboard_scoreboard.sv
// Per-register busy bits for multi-cycle writers.
// Optional ready bypass on a same-cycle write: REGFILE_WRITE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  localparam int AW = $clog2(N_REGS)
) (
  input  logic          clk,
  input  logic          reset_synchronous,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic          i_rsv_en,
  input  logic [AW-1:0] i_rsv_addr,
  input  logic [AW-1:0] i_rd_addr0,
  input  logic [AW-1:0] i_rd_addr1,
  output logic          o_ready0,
  output logic          o_ready1,
  output logic          o_stall
);

  localparam logic [AW-1:0] PC_A = AW'(pc_index(N_REGS));

  logic [N_REGS-1:0] r_busy;
  logic              w_rsv_live;
  logic              w_clr_same;
  logic              w_accept;

  // A write clearing the target frees it in time for the reserve.
  assign w_rsv_live = i_rsv_en && (i_rsv_addr != PC_A);
  assign w_clr_same = i_wr_en && (i_wr_addr == i_rsv_addr);
  assign w_accept   = w_rsv_live && (!r_busy[i_rsv_addr] || w_clr_same);
  assign o_stall    = w_rsv_live && r_busy[i_rsv_addr] && !w_clr_same;

  always_ff @(posedge clk) begin
    if (reset_synchronous) begin
      r_busy <= '0;
    end else begin
      if (i_wr_en)  r_busy[i_wr_addr]  <= 1'b0;
      if (w_accept) r_busy[i_rsv_addr] <= 1'b1;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  assign o_ready0 = (i_rd_addr0 == PC_A) || !r_busy[i_rd_addr0] ||
                    (i_wr_en && (i_wr_addr == i_rd_addr0));
  assign o_ready1 = (i_rd_addr1 == PC_A) || !r_busy[i_rd_addr1] ||
                    (i_wr_en && (i_wr_addr == i_rd_addr1));
`else
  assign o_ready0 = (i_rd_addr0 == PC_A) || !r_busy[i_rd_addr0];
  assign o_ready1 = (i_rd_addr1 == PC_A) || !r_busy[i_rd_addr1];
`endif

endmodule

// File: rtl/register_file_scoreboard.sv
// Parametrised register file with top-index PC and busy scoreboard.
// Optional same-cycle write bypass: REGFILE_WRITE_BYPASS_EN.
module register_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int N_REGS = N_REGS_DEF
) (
  input logic                       clk,
  input logic                       reset_synchronous,
  register_file_scoreboard_if.slave bus
);

  localparam int AW = $clog2(N_REGS);
  localparam logic [AW-1:0] PC_A = AW'(pc_index(N_REGS));

  logic [W-1:0] r_regs [N_REGS];
  logic         w_pc_load;
  logic [W-1:0] w_rd0;
  logic [W-1:0] w_rd1;

  // A general write to the PC index overrides the sequential PC load.
  assign w_pc_load = bus.inp_pc_enable &&
                     !(bus.write_enable && bus.inp_write_address0 == PC_A);

  always_ff @(posedge clk) begin
    if (reset_synchronous) begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (bus.write_enable) r_regs[bus.inp_write_address0] <= bus.inp_write_data;
      if (w_pc_load)        r_regs[PC_A] <= bus.inp_write_data_pc;
    end
  end

  assign w_rd0  = r_regs[bus.inp_read_address0];
  assign w_rd1  = r_regs[bus.inp_read_address1];
  assign bus.out_pc = r_regs[PC_A];

`ifdef REGFILE_WRITE_BYPASS_EN
  always_comb begin
    bus.out_read_data0 = w_rd0;
    bus.out_read_data1 = w_rd1;
    if (bus.write_enable && bus.inp_write_address0 == bus.inp_read_address0)
      bus.out_read_data0 = bus.inp_write_data;
    else if (w_pc_load && bus.inp_read_address0 == PC_A)
      bus.out_read_data0 = bus.inp_write_data_pc;
    if (bus.write_enable && bus.inp_write_address0 == bus.inp_read_address1)
      bus.out_read_data1 = bus.inp_write_data;
    else if (w_pc_load && bus.inp_read_address1 == PC_A)
      bus.out_read_data1 = bus.inp_write_data_pc;
  end
`else
  assign bus.out_read_data0 = w_rd0;
  assign bus.out_read_data1 = w_rd1;
`endif

  regfile_scoreboard #(.N_REGS(N_REGS)) u_sb (
    .clk               (clk),
    .reset_synchronous (reset_synchronous),
    .i_wr_en           (bus.write_enable),
    .i_wr_addr         (bus.inp_write_address0),
    .i_rsv_en          (bus.inp_reserve_enable),
    .i_rsv_addr        (bus.inp_reserve_address),
    .i_rd_addr0        (bus.inp_read_address0),
    .i_rd_addr1        (bus.inp_read_address1),
    .o_ready0          (bus.out_read_ready0),
    .o_ready1          (bus.out_read_ready1),
    .o_stall           (bus.out_reserve_stall)
  );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard (16x32 and 8x16 builds).
// Expected values are queued at stimulus time and popped at each check.
module tb_register_file_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_file_scoreboard_if #(.W(32), .N_REGS(16)) ba();
  register_file_scoreboard_if #(.W(16), .N_REGS(8))  bb();

  register_file_scoreboard #(.W(32), .N_REGS(16)) dut_a (
    .clk(clk), .reset_synchronous(rst), .bus(ba)
  );
  register_file_scoreboard #(.W(16), .N_REGS(8)) dut_b (
    .clk(clk), .reset_synchronous(rst), .bus(bb)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ba.write_enable       = 1'b0;
    ba.inp_reserve_enable = 1'b0;
    ba.inp_pc_enable      = 1'b0;
  endtask

  initial begin
    ba.inp_read_address0 = '0;  ba.inp_read_address1 = '0;
    ba.inp_write_address0 = '0; ba.inp_write_data = '0;
    ba.inp_reserve_address = '0; ba.inp_write_data_pc = '0;
    idle_a();
    bb.inp_read_address0 = '0;  bb.inp_read_address1 = '0;
    bb.write_enable = 1'b0;     bb.inp_write_address0 = '0;
    bb.inp_write_data = '0;     bb.inp_reserve_enable = 1'b0;
    bb.inp_reserve_address = '0; bb.inp_pc_enable = 1'b0;
    bb.inp_write_data_pc = '0;

    tick(); tick();
    rst = 1'b0;
    #1;

    // reset state
    push(0); chk("rst_pc", ba.out_pc);
    push(0); chk("rst_stall", {31'd0, ba.out_reserve_stall});
    for (int a = 0; a < 16; a++) begin
      ba.inp_read_address0 = a[3:0];
      ba.inp_read_address1 = 4'(15 - a);
      #1;
      push(0); chk("rst_rd0", ba.out_read_data0);
      push(0); chk("rst_rd1", ba.out_read_data1);
      push(1); chk("rst_rdy0", {31'd0, ba.out_read_ready0});
      push(1); chk("rst_rdy1", {31'd0, ba.out_read_ready1});
    end

    // reset discards an in-flight reservation
    ba.inp_reserve_enable = 1'b1; ba.inp_reserve_address = 4'd3;
    tick();
    ba.inp_read_address0 = 4'd3;
    #1;
    push(0); chk("r3_busy", {31'd0, ba.out_read_ready0});
    rst = 1'b1;
    tick();
    rst = 1'b0; idle_a();
    #1;
    push(1); chk("r3_rst_rdy", {31'd0, ba.out_read_ready0});

    // write R5, same-cycle and next-cycle read
    ba.write_enable = 1'b1; ba.inp_write_address0 = 4'd5;
    ba.inp_write_data = 32'hDEADBEEF; ba.inp_read_address0 = 4'd5;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    push(32'hDEADBEEF);
`else
    push(0);
`endif
    chk("r5_same", ba.out_read_data0);
    tick(); idle_a();
    #1;
    push(32'hDEADBEEF); chk("r5_next", ba.out_read_data0);

    // reserve R2, retry stall, clear by write
    ba.inp_reserve_enable = 1'b1; ba.inp_reserve_address = 4'd2;
    ba.inp_read_address1 = 4'd2;
    #1;
    push(0); chk("r2_rsv_stall", {31'd0, ba.out_reserve_stall});
    tick();
    push(0); chk("r2_rdy1", {31'd0, ba.out_read_ready1});
    push(1); chk("r2_restall", {31'd0, ba.out_reserve_stall});
    tick(); idle_a();
    ba.write_enable = 1'b1; ba.inp_write_address0 = 4'd2;
    ba.inp_write_data = 32'h11;
    tick(); idle_a();
    #1;
    push(1); chk("r2_clr_rdy", {31'd0, ba.out_read_ready1});
    push(32'h11); chk("r2_data", ba.out_read_data1);

    // reserve busy reg while its write clears it: accepted
    ba.inp_reserve_enable = 1'b1; ba.inp_reserve_address = 4'd2;
    tick();
    ba.write_enable = 1'b1; ba.inp_write_address0 = 4'd2;
    ba.inp_write_data = 32'h33;
    #1;
    push(0); chk("r2_exc_stall", {31'd0, ba.out_reserve_stall});
    tick(); idle_a();
    #1;
    push(0); chk("r2_exc_rdy", {31'd0, ba.out_read_ready1});
    push(32'h33); chk("r2_exc_data", ba.out_read_data1);

    // same-cycle write + reserve of R4
    ba.write_enable = 1'b1; ba.inp_write_address0 = 4'd4;
    ba.inp_write_data = 32'h22;
    ba.inp_reserve_enable = 1'b1; ba.inp_reserve_address = 4'd4;
    ba.inp_read_address0 = 4'd4;
    #1;
    push(0); chk("r4_stall", {31'd0, ba.out_reserve_stall});
    tick(); idle_a();
    #1;
    push(32'h22); chk("r4_data", ba.out_read_data0);
    push(0); chk("r4_rdy", {31'd0, ba.out_read_ready0});

    // write R6 and reserve R7 together
    ba.write_enable = 1'b1; ba.inp_write_address0 = 4'd6;
    ba.inp_write_data = 32'h66;
    ba.inp_reserve_enable = 1'b1; ba.inp_reserve_address = 4'd7;
    ba.inp_read_address0 = 4'd6; ba.inp_read_address1 = 4'd7;
    tick(); idle_a();
    #1;
    push(32'h66); chk("r6_data", ba.out_read_data0);
    push(1); chk("r6_rdy", {31'd0, ba.out_read_ready0});
    push(0); chk("r7_rdy", {31'd0, ba.out_read_ready1});

    // R0 is writable
    ba.write_enable = 1'b1; ba.inp_write_address0 = 4'd0;
    ba.inp_write_data = 32'hA5A5_0001; ba.inp_read_address0 = 4'd0;
    tick(); idle_a();
    #1;
    push(32'hA5A5_0001); chk("r0_data", ba.out_read_data0);

    // PC: branch override, then sequential load
    ba.inp_pc_enable = 1'b1; ba.inp_write_data_pc = 32'h104;
    ba.write_enable = 1'b1; ba.inp_write_address0 = 4'd15;
    ba.inp_write_data = 32'h200;
    tick(); idle_a();
    #1;
    push(32'h200); chk("pc_override", ba.out_pc);
    ba.inp_pc_enable = 1'b1; ba.inp_write_data_pc = 32'h204;
    tick(); idle_a();
    ba.inp_read_address0 = 4'd15;
    #1;
    push(32'h204); chk("pc_load", ba.out_pc);
    push(32'h204); chk("pc_read", ba.out_read_data0);

    // reserve on PC ignored
    ba.inp_reserve_enable = 1'b1; ba.inp_reserve_address = 4'd15;
    #1;
    push(0); chk("pc_rsv_stall", {31'd0, ba.out_reserve_stall});
    tick(); idle_a();
    #1;
    push(1); chk("pc_rdy", {31'd0, ba.out_read_ready0});
    tick();
    push(32'h204); chk("pc_hold", ba.out_pc);

    // 8x16 build, PC at index 7
    bb.write_enable = 1'b1; bb.inp_write_address0 = 3'd6;
    bb.inp_write_data = 16'hABCD;
    bb.inp_pc_enable = 1'b1; bb.inp_write_data_pc = 16'h0010;
    bb.inp_read_address0 = 3'd6; bb.inp_read_address1 = 3'd7;
    tick();
    bb.write_enable = 1'b0; bb.inp_pc_enable = 1'b0;
    #1;
    push(32'hABCD); chk("b_r6", {16'd0, bb.out_read_data0});
    push(32'h0010); chk("b_pc", {16'd0, bb.out_pc});
    push(32'h0010); chk("b_rd_pc", {16'd0, bb.out_read_data1});
    bb.inp_pc_enable = 1'b1; bb.inp_write_data_pc = 16'h0012;
    tick();
    bb.inp_pc_enable = 1'b0;
    #1;
    push(32'h0012); chk("b_pc2", {16'd0, bb.out_pc});

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL leftover: observed=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- Parametrised successor to the 16x32 register file. Adds configurable depth and width, and a dedicated PC register at the top index with load/override arbitration.
- Adds a per-register busy scoreboard for multi-cycle writers, e.g. loads. Read ports report operand readiness so the future multi-cycle/pipelined datapath can stall.
- Sits between decode (read/reserve) and writeback (write/clear).

Parameters:
- W, 32, data width in bits.
- N_REGS, 16, number of architectural registers; power of two, at least 4.
- AW, $clog2(N_REGS), address width; derived, never overridden.
- PC_INDEX, N_REGS-1, index of the program-counter register; derived.

Ports:
- clk  input  1  rising-edge clock
- reset_synchronous  input  1  synchronous, active-high reset
- inp_read_address0  input  AW  read port 0 address
- inp_read_address1  input  AW  read port 1 address
- out_read_data0  output  W  read port 0 data
- out_read_data1  output  W  read port 1 data
- out_read_ready0  output  1  register at address0 not busy
- out_read_ready1  output  1  register at address1 not busy
- write_enable  input  1  general write strobe (writeback)
- inp_write_address0  input  AW  general write address
- inp_write_data  input  W  general write data
- inp_reserve_enable  input  1  mark destination busy (issue of a multi-cycle writer)
- inp_reserve_address  input  AW  register to reserve
- out_reserve_stall  output  1  reserve rejected this cycle
- inp_pc_enable  input  1  load next PC
- inp_write_data_pc  input  W  next-PC value
- out_pc  output  W  current PC register value

Behaviour:
- Clock and reset: one clock, clk. reset_synchronous is synchronous and active-high. On a reset edge all N_REGS registers go to 0 and all busy bits to 0. Reset overrides every write, reserve and PC load in that cycle, including mid-operation, so in-flight reservations are discarded.
- Reset values of outputs after reset: out_pc=0; out_read_data0/1=0; out_read_ready0/1=1; out_reserve_stall=0.
- Reads:
  - Combinational, zero latency, from the registered state.
  - Read of PC_INDEX returns out_pc.
  - out_read_readyN = !busy[addrN]. PC_INDEX is always ready.
- General write:
  - On clk edge, if write_enable, reg[inp_write_address0] <= inp_write_data and busy[inp_write_address0] <= 0.
  - Any index may be written, including 0 (no hardwired zero).
- PC update:
  - If inp_pc_enable, reg[PC_INDEX] <= inp_write_data_pc.
  - If write_enable targets PC_INDEX in the same cycle, the general write wins (branch override) and inp_write_data_pc is dropped.
  - With neither active, PC holds.
- Reserve:
  - Accepted when inp_reserve_enable=1, inp_reserve_address != PC_INDEX, and the target is not busy. Accepted reserve sets busy[addr] <= 1.
  - Reserve on PC_INDEX is ignored: no stall, no state change.
  - Reserve on a busy register is rejected: out_reserve_stall=1 combinationally that cycle, busy unchanged, caller retries.
  - Exception: if write_enable clears that same register in the same cycle, the reserve is accepted (no stall) and busy ends at 1.
- Simultaneous events, same address:
  - Write plus reserve: data is written and busy ends at 1 (reserve wins).
  - Write to one register plus reserve of another: both take effect.
- Write to a non-busy register is legal and leaves busy=0.
- No latency beyond a single edge. State update is one cycle; outputs reflect it the next cycle unless the bypass below is compiled in.

Optional Feature:
- REGFILE_WRITE_BYPASS_EN defined:
  - If write_enable and inp_write_address0 equals a read address, that port returns inp_write_data in the same cycle and its ready flag is 1.
  - A PC_INDEX read with inp_pc_enable and no general write to PC returns inp_write_data_pc.
- Not defined: reads always return pre-edge register contents; the new value is visible one cycle later.

Decomposition:
- Package regfile_pkg holds:
  - default W and N_REGS localparams;
  - function pc_index(n) returning n-1;
  - typedef for the busy-vector width.
- Natural sub-module regfile_scoreboard: N_REGS busy bits with set/clear/stall logic and two ready lookups.
- Data storage and the PC arbitration stay in the top module; existing register and decoder primitives are reused.

Test Plan:
- Reset then read every address -> data 0, ready 1, out_pc 0; repeat reset asserted mid-reservation on R3 -> busy cleared, ready0=1 for address 3.
- write_enable, address 5, data 0xDEADBEEF; next cycle read0=5 -> 0xDEADBEEF. Same-cycle read returns old value unless bypass compiled in, in which case 0xDEADBEEF.
- Reserve R2; next cycle read1=2 -> ready1=0. Reserve R2 again -> stall=1. Write R2=0x11 -> next cycle ready1=1, data 0x11.
- Same-cycle write R4=0x22 plus reserve R4 -> stall=0; next cycle data 0x22, ready=0.
- inp_pc_enable with 0x104 and write_enable to PC_INDEX with 0x200 -> out_pc=0x200. Next cycle pc_enable only with 0x204 -> out_pc=0x204. Reserve on PC_INDEX -> stall=0, PC ready stays 1.
- Parametrised build W=16, N_REGS=8 -> PC_INDEX=7; write R6=0xABCD, read back 0xABCD; PC auto-load functional.
